// File: rtl/ov7670_frame_ctrl.sv
// Frame-level sequencer between the OV7670 capture stage and the pixel FIFO (pclk domain).
// Optional frame decimation is enabled by defining OV7670_FRAME_CTRL_DECIM_EN (adds frame_skip).
module ov7670_frame_ctrl #(
    parameter int H_PIXELS = 640,
    parameter int V_LINES  = 480
) (
    input  logic        pclk,
    input  logic        resetn,
    input  logic        cap_start,
    input  logic        cap_stop,
    input  logic        cap_continuous,
    input  logic        frame_start,
    input  logic        frame_end,
    input  logic        pix_valid,
    input  logic [15:0] pix_data,
    input  logic        fifo_full,
`ifdef OV7670_FRAME_CTRL_DECIM_EN
    input  logic [3:0]  frame_skip,
`endif
    output logic        fifo_wr_en,
    output logic [15:0] fifo_wr_data,
    output logic        busy,
    output logic        frame_done,
    output logic        frame_ovf,
    output logic        size_err,
    output logic [15:0] frame_count,
    output logic [7:0]  drop_count,
    output logic [1:0]  state_dbg
);

    // Handshake: fifo_wr_en is a write strobe; the FIFO accepts fifo_wr_data in any
    // cycle where fifo_wr_en is high. fifo_full is sampled when the pixel arrives.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        CAPT = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t      state;
    logic [15:0] pix_cnt;
    logic [15:0] line_cnt;
    logic        stop_pending;
`ifdef OV7670_FRAME_CTRL_DECIM_EN
    logic [3:0]  skip_cnt;
`endif

    logic        wr_ok;
    logic [15:0] pix_nxt;
    logic [15:0] line_nxt;
    logic        geom_ok;
    logic        rearm;
    logic        closing;

    assign busy      = (state != IDLE);
    assign state_dbg = state;

    // Counter values including a pixel accepted this cycle, so a frame_end that
    // coincides with the last pixel is judged on the completed count.
    always_comb begin
        wr_ok    = pix_valid && !fifo_full;
        pix_nxt  = pix_cnt;
        line_nxt = line_cnt;
        if (wr_ok) begin
            if (pix_cnt == 16'(H_PIXELS - 1)) begin
                pix_nxt  = 16'd0;
                line_nxt = line_cnt + 16'd1;
            end else begin
                pix_nxt = pix_cnt + 16'd1;
            end
        end
        geom_ok = (line_nxt == 16'(V_LINES)) && (pix_nxt == 16'd0);
        rearm   = cap_continuous && !(stop_pending || cap_stop);
        closing = frame_end && ((state == DROP) || ((state == CAPT) && !frame_start));
    end

    always_ff @(posedge pclk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            pix_cnt      <= 16'd0;
            line_cnt     <= 16'd0;
            stop_pending <= 1'b0;
            fifo_wr_en   <= 1'b0;
            fifo_wr_data <= 16'd0;
            frame_done   <= 1'b0;
            frame_ovf    <= 1'b0;
            size_err     <= 1'b0;
            frame_count  <= 16'd0;
            drop_count   <= 8'd0;
`ifdef OV7670_FRAME_CTRL_DECIM_EN
            skip_cnt     <= 4'd0;
`endif
        end else begin
            fifo_wr_en <= 1'b0;
            frame_done <= 1'b0;
            frame_ovf  <= 1'b0;
            size_err   <= 1'b0;

            case (state)
                IDLE: begin
                    if (cap_start && !cap_stop) begin
                        state <= ARM;
`ifdef OV7670_FRAME_CTRL_DECIM_EN
                        skip_cnt <= frame_skip;
`endif
                    end
                end

                ARM: begin
                    if (cap_stop) begin
                        state        <= IDLE;
                        stop_pending <= 1'b0;
                    end else if (frame_start) begin
`ifdef OV7670_FRAME_CTRL_DECIM_EN
                        if (skip_cnt != 4'd0) begin
                            skip_cnt <= skip_cnt - 4'd1;
                        end else begin
                            state    <= CAPT;
                            pix_cnt  <= 16'd0;
                            line_cnt <= 16'd0;
                        end
`else
                        state    <= CAPT;
                        pix_cnt  <= 16'd0;
                        line_cnt <= 16'd0;
`endif
                    end
                end

                CAPT: begin
                    if (cap_stop) stop_pending <= 1'b1;
                    if (frame_start) begin
                        // Missing frame_end: restart geometry tracking on the new frame.
                        size_err <= 1'b1;
                        pix_cnt  <= 16'd0;
                        line_cnt <= 16'd0;
                    end else if (pix_valid && fifo_full) begin
                        if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
                        if (frame_end) frame_ovf <= 1'b1;
                        else           state     <= DROP;
                    end else begin
                        if (wr_ok) begin
                            fifo_wr_en   <= 1'b1;
                            fifo_wr_data <= pix_data;
                            pix_cnt      <= pix_nxt;
                            line_cnt     <= line_nxt;
                        end
                        if (frame_end) begin
                            size_err    <= !geom_ok;
                            frame_done  <= 1'b1;
                            frame_count <= frame_count + 16'd1;
                        end
                    end
                end

                DROP: begin
                    if (cap_stop) stop_pending <= 1'b1;
                    if (frame_end) frame_ovf <= 1'b1;
                end

                default: state <= IDLE;
            endcase

            // End-of-frame routing shared by CAPT and DROP; overrides the stop flag set above.
            if (closing) begin
                if (rearm) begin
                    state <= ARM;
`ifdef OV7670_FRAME_CTRL_DECIM_EN
                    skip_cnt <= frame_skip;
`endif
                end else begin
                    state        <= IDLE;
                    stop_pending <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ov7670_frame_ctrl.sv
// Directed bench for ov7670_frame_ctrl (H=4, V=2) with a write scoreboard and pulse monitor.
module tb_ov7670_frame_ctrl;

    logic        pclk = 1'b0;
    logic        resetn = 1'b0;
    logic        cap_start = 1'b0;
    logic        cap_stop = 1'b0;
    logic        cap_continuous = 1'b0;
    logic        frame_start = 1'b0;
    logic        frame_end = 1'b0;
    logic        pix_valid = 1'b0;
    logic [15:0] pix_data = 16'd0;
    logic        fifo_full = 1'b0;
`ifdef OV7670_FRAME_CTRL_DECIM_EN
    logic [3:0]  frame_skip = 4'd0;
`endif
    logic        fifo_wr_en;
    logic [15:0] fifo_wr_data;
    logic        busy;
    logic        frame_done;
    logic        frame_ovf;
    logic        size_err;
    logic [15:0] frame_count;
    logic [7:0]  drop_count;
    logic [1:0]  state_dbg;

    ov7670_frame_ctrl #(.H_PIXELS(4), .V_LINES(2)) dut (
        .pclk(pclk), .resetn(resetn),
        .cap_start(cap_start), .cap_stop(cap_stop), .cap_continuous(cap_continuous),
        .frame_start(frame_start), .frame_end(frame_end),
        .pix_valid(pix_valid), .pix_data(pix_data), .fifo_full(fifo_full),
`ifdef OV7670_FRAME_CTRL_DECIM_EN
        .frame_skip(frame_skip),
`endif
        .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .busy(busy),
        .frame_done(frame_done), .frame_ovf(frame_ovf), .size_err(size_err),
        .frame_count(frame_count), .drop_count(drop_count), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [15:0] exp_q[$];
    int          exp_t_q[$];
    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0, ovf_cnt = 0, serr_cnt = 0;
    int d0, o0, s0;
    logic [15:0] dseq = 16'h1000;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic snap();
        d0 = done_cnt; o0 = ovf_cnt; s0 = serr_cnt;
    endtask

    // ---------------- monitor ----------------
    always @(negedge pclk) begin
        if (resetn) begin
            if (frame_done) done_cnt++;
            if (frame_ovf)  ovf_cnt++;
            if (size_err)   serr_cnt++;
            if (fifo_wr_en) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL wr_unexpected: got data %h at cycle %0d, expected no write", fifo_wr_data, cyc);
                end else begin
                    logic [15:0] ed;
                    int et;
                    ed = exp_q.pop_front();
                    et = exp_t_q.pop_front();
                    if (ed !== fifo_wr_data || et != cyc) begin
                        n_errors++;
                        $display("FAIL wr_data: got %h at cycle %0d, expected %h at cycle %0d",
                                 fifo_wr_data, cyc, ed, et);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic pv, input logic [15:0] d, input logic fs, input logic fe,
                         input logic full, input logic stt, input logic stp, input logic exp_wr);
        @(posedge pclk);
        #1;
        pix_valid = pv; pix_data = d; frame_start = fs; frame_end = fe;
        fifo_full = full; cap_start = stt; cap_stop = stp;
        if (exp_wr) begin
            exp_q.push_back(d);
            exp_t_q.push_back(cyc + 1);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic run_frame(input int npix, input logic wr, input int stop_at, input logic end_merge);
        drive(1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < npix; i++) begin
            drive(1'b1, dseq, 1'b0, end_merge && (i == npix - 1), 1'b0, 1'b0, (i == stop_at), wr);
            dseq = dseq + 16'd1;
        end
        if (!end_merge) drive(1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);
    endtask

    task automatic arm();
        drive(1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        idle(2);
        check("rst_wr_en", fifo_wr_en, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_count", frame_count, 0);
        check("rst_drop_count", drop_count, 0);
        check("rst_state", state_dbg, 0);
        @(posedge pclk); #1; resetn = 1'b1;
        idle(1);

        // Good single-shot 4x2 frame
        snap(); arm(); idle(1);
        check("t1_busy_armed", busy, 1);
        run_frame(8, 1'b1, -1, 1'b0);
        check("t1_done", done_cnt - d0, 1);
        check("t1_size_err", serr_cnt - s0, 0);
        check("t1_frame_count", frame_count, 1);
        check("t1_idle", busy, 0);

        // Overflow on pixel 3
        snap(); arm();
        drive(1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 16'hA001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 16'hA002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 16'hA003, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 16'hA004, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t2_state_drop", state_dbg, 3);
        drive(1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);
        check("t2_ovf", ovf_cnt - o0, 1);
        check("t2_done", done_cnt - d0, 0);
        check("t2_drop_count", drop_count, 1);
        check("t2_frame_count", frame_count, 1);
        check("t2_idle", busy, 0);

        // Short frame (7 pixels)
        snap(); arm();
        run_frame(7, 1'b1, -1, 1'b0);
        check("t3_size_err", serr_cnt - s0, 1);
        check("t3_done", done_cnt - d0, 1);
        check("t3_frame_count", frame_count, 2);

        // Last pixel coincides with frame_end
        snap(); arm();
        run_frame(8, 1'b1, -1, 1'b1);
        check("t3b_size_err", serr_cnt - s0, 0);
        check("t3b_done", done_cnt - d0, 1);
        check("t3b_frame_count", frame_count, 3);

        // frame_start during CAPT restarts the frame
        snap(); arm();
        drive(1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, dseq, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            dseq = dseq + 16'd1;
        end
        idle(1);
        check("t7_no_done_yet", done_cnt - d0, 0);
        run_frame(8, 1'b1, -1, 1'b0);
        check("t7_size_err", serr_cnt - s0, 1);
        check("t7_done", done_cnt - d0, 1);
        check("t7_frame_count", frame_count, 4);

        // Continuous with stop mid-frame 2
        snap(); cap_continuous = 1'b1; arm();
        run_frame(8, 1'b1, -1, 1'b0);
        check("t4_rearmed", state_dbg, 1);
        run_frame(8, 1'b1, 3, 1'b0);
        check("t4_idle_after_f2", busy, 0);
        run_frame(8, 1'b0, -1, 1'b0);
        check("t4_done", done_cnt - d0, 2);
        check("t4_frame_count", frame_count, 6);
        cap_continuous = 1'b0;

        // start+stop together, pixels while idle
        drive(1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(1);
        check("t5_busy", busy, 0);
        check("t5_state", state_dbg, 0);
        for (int i = 0; i < 3; i++) drive(1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);

        // Reset mid-CAPT with a write in flight
        arm();
        drive(1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 16'hC001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 16'hC002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge pclk); #2;
        check("t5_wr_before_reset", fifo_wr_en, 1);
        resetn = 1'b0;
        #1;
        check("t5_rst_wr_en", fifo_wr_en, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_frame_count", frame_count, 0);
        check("t5_rst_drop_count", drop_count, 0);
        check("t5_rst_wr_data", fifo_wr_data, 0);
        pix_valid = 1'b0;
        @(posedge pclk); #1; resetn = 1'b1;
        idle(1);

`ifdef OV7670_FRAME_CTRL_DECIM_EN
        // Decimation: skip 2, capture 1, repeating
        snap(); frame_skip = 4'd2; cap_continuous = 1'b1; arm();
        for (int f = 1; f <= 6; f++) run_frame(8, (f % 3) == 0, -1, 1'b0);
        check("t6_done", done_cnt - d0, 2);
        check("t6_frame_count", frame_count, 2);
        check("t6_armed", state_dbg, 1);
        cap_continuous = 1'b0;
        drive(1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(1);
        check("t6_stopped", busy, 0);
`endif

        idle(2);
        check("sb_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
